// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// the hard-wired zero register, the mul/div latency default, the pipeline
// control mode and the register compare helper.
package pipe_pkg;

    localparam int MD_LAT_DEFAULT = 4;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    localparam logic [4:0] R0 = 5'd0;

    typedef enum logic [1:0] {
        PIPE_RUN   = 2'd0,
        PIPE_STALL = 2'd1,
        PIPE_FLUSH = 2'd2
    } pipe_mode_e;

    // A source matches a producer only if it is really read, the producer
    // really writes, and the register is not r0 (r0 is never written).
    function automatic logic reg_match(input logic       use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] dst,
                                       input logic       wen);
        return use_src && wen && (src != R0) && (src == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the ID-stage datapath and the hazard controller.
// master = pipeline side (drives register numbers, consumes enables),
// slave  = controller side.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_md;
    logic [4:0] EXwn;
    logic [4:0] MEMwn;
    logic       EXwreg;
    logic       MEMwreg;
    logic       EXm2reg;
    logic       ex_br_taken;

    logic       IFwip;
    logic       IDwir;
    logic       if_flush;
    logic       id_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       md_start;
    logic       md_busy;
    logic       md_done;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_md,
        output EXwn, MEMwn, EXwreg, MEMwreg, EXm2reg, ex_br_taken,
        input  IFwip, IDwir, if_flush, id_bubble, fwd_a, fwd_b,
        input  md_start, md_busy, md_done
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_md,
        input  EXwn, MEMwn, EXwreg, MEMwreg, EXm2reg, ex_br_taken,
        output IFwip, IDwir, if_flush, id_bubble, fwd_a, fwd_b,
        output md_start, md_busy, md_done
    );

endinterface

// File: rtl/pipe_md_sched.sv
// Mul/div occupancy scheduler. Holds the only state of the controller: a
// down-counter loaded with MD_LAT on launch. busy covers MD_LAT cycles after
// launch; the last busy cycle (count 1) is "done" and already accepts the
// next launch, so back-to-back ops run with no gap.
module pipe_md_sched
    import pipe_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT
) (
    input  logic clk,
    input  logic clrn,
    input  logic id_md,
    input  logic launch_ok,
    output logic md_start,
    output logic md_busy,
    output logic md_done,
    output logic md_hold
);

    localparam int               CNT_W    = $clog2(MD_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] md_cnt;

    assign md_start = clrn && id_md && launch_ok;

    // Occupancy counter: reload on launch, otherwise count down and stop at 0.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            md_cnt <= '0;
        end else if (md_start) begin
            md_cnt <= LAT_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_ONE;
        end
    end

    assign md_busy = clrn && (md_cnt != '0);
    assign md_done = clrn && (md_cnt == CNT_ONE);
    assign md_hold = (md_cnt > CNT_ONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage interlock controller: RAW detection against EX/MEM, load-use and
// mul/div conflict stalls, taken-branch flush, and PC/IR write gating.
// Build option: PIPE_FWD_EN enables EX/MEM forwarding; without it every
// EX/MEM RAW match stalls and the forward selects stay at the regfile.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               clrn,
    pipe_hazard_ctrl_if.slave  bus
);

    logic       rs_ex;
    logic       rs_mem;
    logic       rt_ex;
    logic       rt_mem;
    logic       stall_ld;
    logic       stall_md;
    logic       stall_raw;
    logic       md_hold;
    logic       launch_ok;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    pipe_mode_e mode;

    assign rs_ex  = reg_match(bus.id_use_rs, bus.id_rs, bus.EXwn,  bus.EXwreg);
    assign rs_mem = reg_match(bus.id_use_rs, bus.id_rs, bus.MEMwn, bus.MEMwreg);
    assign rt_ex  = reg_match(bus.id_use_rt, bus.id_rt, bus.EXwn,  bus.EXwreg);
    assign rt_mem = reg_match(bus.id_use_rt, bus.id_rt, bus.MEMwn, bus.MEMwreg);

    assign stall_ld = (rs_ex || rt_ex) && bus.EXm2reg;
    assign stall_md = bus.id_md && md_hold;

`ifdef PIPE_FWD_EN
    assign stall_raw = 1'b0;

    // Operand select: the younger producer in EX wins over the one in MEM.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (rs_ex) begin
            fwd_a_sel = FWD_EX;
        end else if (rs_mem) begin
            fwd_a_sel = FWD_MEM;
        end
        if (rt_ex) begin
            fwd_b_sel = FWD_EX;
        end else if (rt_mem) begin
            fwd_b_sel = FWD_MEM;
        end
    end
`else
    assign stall_raw = rs_ex || rs_mem || rt_ex || rt_mem;
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    // Pipeline mode with reset forcing run, then branch flush over any stall.
    always_comb begin
        mode = PIPE_RUN;
        if (!clrn) begin
            mode = PIPE_RUN;
        end else if (bus.ex_br_taken) begin
            mode = PIPE_FLUSH;
        end else if (stall_ld || stall_md || stall_raw) begin
            mode = PIPE_STALL;
        end
    end

    assign launch_ok = (mode == PIPE_RUN);

    // Translate the mode into PC/IR write enables, flush and bubble.
    always_comb begin
        bus.IFwip     = 1'b1;
        bus.IDwir     = 1'b1;
        bus.if_flush  = 1'b0;
        bus.id_bubble = 1'b0;
        case (mode)
            PIPE_FLUSH: begin
                bus.if_flush  = 1'b1;
                bus.id_bubble = 1'b1;
            end
            PIPE_STALL: begin
                bus.IFwip     = 1'b0;
                bus.IDwir     = 1'b0;
                bus.id_bubble = 1'b1;
            end
            default: begin
                bus.id_bubble = 1'b0;
            end
        endcase
    end

    assign bus.fwd_a = clrn ? fwd_a_sel : FWD_RF;
    assign bus.fwd_b = clrn ? fwd_b_sel : FWD_RF;

    pipe_md_sched #(
        .MD_LAT   (MD_LAT)
    ) u_md_sched (
        .clk      (clk),
        .clrn     (clrn),
        .id_md    (bus.id_md),
        .launch_ok(launch_ok),
        .md_start (bus.md_start),
        .md_busy  (bus.md_busy),
        .md_done  (bus.md_done),
        .md_hold  (md_hold)
    );

endmodule
